interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Receiving end of the peripheral interrupt lines (system timer, UART, GPIO, ...).
- Detects rising edges on each source, latches them as pending, masks them, and selects the highest-priority one.
- Presents the selected interrupt to the CPU through a request/acknowledge handshake, then holds it in service until software writes end-of-interrupt.
- Register side sits on the I/O logic bus with the same select/write/read port shape as the other peripherals.

Parameters:
- NUM_SOURCES, 8, number of interrupt inputs; 1..32.
- ID_WIDTH, 3, width of the source ID; must equal $clog2(NUM_SOURCES), minimum 1.

Ports:
- Clock  input  1  system clock; all state on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- IntSrc  input  NUM_SOURCES  interrupt lines from peripherals; bit 0 = system timer.
- RegAddress  input  4  register select within block.
- BlockSelect  input  1  block decoded by the address decoder.
- WrEn  input  1  write strobe, qualified by BlockSelect.
- WrData  input  32  write data.
- RdData  output  32  combinational read data; 0 when BlockSelect=0 or address unmapped.
- CpuIntReq  output  1  interrupt request to CPU.
- CpuIntId  output  ID_WIDTH  ID of the requested/in-service source.
- CpuIntAck  input  1  one-cycle CPU acknowledge.

Behaviour:
- Registers (RegAddress):
  - 4'h0 CR: bit0 = global enable; R/W.
  - 4'h1 IER: per-source enable; R/W.
  - 4'h2 IPR: pending bits; read; write-1-to-clear.
  - 4'h3 ISR: read-only; bit31 = in-service, bits[ID_WIDTH-1:0] = CpuIntId.
  - 4'h4 EOI: write-only, any data.
  - Bits above NUM_SOURCES read 0 and ignore writes.
- Reset values: CR=0, IER=0, IPR=0, edge history=0, state IDLE, CpuIntReq=0, CpuIntId=0.
- Edge detect:
  - Registered copy of IntSrc per source.
  - Pending bit sets on a cycle where IntSrc=1 and the previous sample=0, regardless of IER/CR.
  - A level held high sets pending once only.
- Set beats clear: an edge and a W1C to the same bit in the same cycle leaves the bit set.
- Eligible = IPR & IER, gated by CR[0]. Priority: lowest index wins.
- State machine:
  - IDLE: if eligible≠0, latch winning ID into CpuIntId and go REQ. CpuIntReq=0.
  - REQ: CpuIntReq=1 and CpuIntId stable.
    - On CpuIntAck=1: clear IPR[CpuIntId], drop CpuIntReq, go SERVICE.
    - A request, once entered, is not withdrawn by IER/CR/IPR writes; Ack still proceeds.
    - An Ack edge that coincides with a new edge on the same source: set wins, so the bit stays pending.
  - SERVICE: CpuIntReq=0, ISR bit31=1.
    - EOI write returns to IDLE.
    - Newer pending sources wait; there is no nesting.
  - CpuIntAck outside REQ and EOI outside SERVICE are ignored.
- Latency:
  - Edge sampled at clock edge k → IPR bit visible after k.
  - CpuIntReq high after k+1 if eligible and IDLE.
  - After an EOI write at edge m, the next eligible source raises CpuIntReq after m+1.
- Reset asserted mid-operation forces all state to reset values immediately; pending interrupts are lost.

Optional Feature:
- Macro INTC_SW_TRIGGER_EN.
- Defined:
  - Register 4'h5 SWTR, write-only.
  - Writing 1s sets the corresponding IPR bits, same cycle-priority as an edge.
  - Used for software interrupts and self-test.
- Undefined:
  - 4'h5 is unmapped; writes are ignored and reads return 0.

Test Plan:
1. Reset → RdData at 4'h0/1/2/3 all 0; CpuIntReq=0, CpuIntId=0.
2. CR=1, IER=8'h01, pulse IntSrc[0] one cycle → IPR=1 after 1 clock, CpuIntReq=1 with CpuIntId=0 after 2. Ack → IPR=0, ISR=32'h8000_0000. EOI → ISR=0, state IDLE.
3. IER=8'hFF, CR=1, raise IntSrc[5] and IntSrc[2] in the same cycle → CpuIntId=2 first. After Ack+EOI → CpuIntId=5.
4. CR=0, edge on IntSrc[3] → IPR=8'h08, no request. Write IPR=8'h08 → IPR=0. Repeat, then write CR=1 → request ID 3.
5. Hold IntSrc[1] high 10 cycles → IPR[1] set only once. In REQ, write IER=0 → CpuIntReq stays 1 until Ack.
6. Assert Reset during SERVICE → CpuIntReq=0, IPR=0, ISR=0. With INTC_SW_TRIGGER_EN defined, write SWTR=8'h10 → IPR=8'h10 → request ID 4.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// -----------------------------------------------------------------------------
// interrupt_controller_if
//
// Purpose: register-bus bundle between the I/O address decoder / CPU side and
// the interrupt controller. It has the same select/write/read shape as the
// other peripherals on the I/O logic bus.
//
// Signals:
//   RegAddress  [3:0]   register select within the block
//   BlockSelect         block decoded by the address decoder
//   WrEn                write strobe, qualified by BlockSelect
//   WrData      [31:0]  write data
//   RdData      [31:0]  combinational read data from the peripheral
//
// Modports:
//   master - bus side (drives address/select/write, receives read data)
//   slave  - peripheral side (the interrupt controller)
// -----------------------------------------------------------------------------
interface interrupt_controller_if;
  logic [3:0]  RegAddress;
  logic        BlockSelect;
  logic        WrEn;
  logic [31:0] WrData;
  logic [31:0] RdData;

  modport master (
    output RegAddress,
    output BlockSelect,
    output WrEn,
    output WrData,
    input  RdData
  );

  modport slave (
    input  RegAddress,
    input  BlockSelect,
    input  WrEn,
    input  WrData,
    output RdData
  );
endinterface

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Purpose: receives peripheral interrupt lines, detects rising edges, latches
// them as pending, masks them, picks the lowest-index eligible source and
// presents it to the CPU with a request/acknowledge handshake. The source is
// then held in service until software writes end-of-interrupt.
//
// Parameters:
//   NUM_SOURCES  number of interrupt inputs (1..32)
//   ID_WIDTH     source ID width, $clog2(NUM_SOURCES) with a minimum of 1
//
// Ports:
//   Clock        system clock, all state on the rising edge
//   Reset        asynchronous active-low reset
//   IntSrc       interrupt lines from peripherals (bit 0 = system timer)
//   bus          register bus (interrupt_controller_if.slave)
//   CpuIntReq    interrupt request to the CPU
//   CpuIntId     ID of the requested / in-service source
//   CpuIntAck    one-cycle CPU acknowledge
//
// Register map (RegAddress):
//   4'h0 CR   bit0 global enable, R/W
//   4'h1 IER  per-source enable, R/W
//   4'h2 IPR  pending bits, read / write-1-to-clear
//   4'h3 ISR  read-only, bit31 in-service, low bits = CpuIntId
//   4'h4 EOI  write-only, any data
//   4'h5 SWTR write-only, sets IPR bits (only with INTC_SW_TRIGGER_EN defined;
//             otherwise unmapped)
//
// Build option: define INTC_SW_TRIGGER_EN to enable the software trigger
// register.
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int NUM_SOURCES = 8,
  parameter int ID_WIDTH    = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NUM_SOURCES-1:0] IntSrc,
  interrupt_controller_if.slave  bus,
  output logic                   CpuIntReq,
  output logic [ID_WIDTH-1:0]    CpuIntId,
  input  logic                   CpuIntAck
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic                   cr_q,    cr_d;
  logic [NUM_SOURCES-1:0] ier_q,   ier_d;
  logic [NUM_SOURCES-1:0] ipr_q,   ipr_d;
  logic [NUM_SOURCES-1:0] src_q;
  logic [1:0]             state_q, state_d;
  logic [ID_WIDTH-1:0]    id_q,    id_d;

  logic                   wr_en;
  logic                   wr_cr, wr_ier, wr_ipr, wr_eoi;
  logic [NUM_SOURCES-1:0] wr_src_bits;
  logic [NUM_SOURCES-1:0] edge_set;
  logic [NUM_SOURCES-1:0] sw_set;
  logic [NUM_SOURCES-1:0] ack_clr;
  logic [NUM_SOURCES-1:0] set_vec, clr_vec;
  logic [NUM_SOURCES-1:0] eligible;
  logic [ID_WIDTH-1:0]    win_id;
  logic [31:0]            rd_data;
  logic                   unused_wrdata;

  // ---------------------------------------------------------------------------
  // Register write decode
  // ---------------------------------------------------------------------------
  assign wr_en       = bus.BlockSelect & bus.WrEn;
  assign wr_cr       = wr_en && (bus.RegAddress == 4'h0);
  assign wr_ier      = wr_en && (bus.RegAddress == 4'h1);
  assign wr_ipr      = wr_en && (bus.RegAddress == 4'h2);
  assign wr_eoi      = wr_en && (bus.RegAddress == 4'h4);
  assign wr_src_bits = bus.WrData[NUM_SOURCES-1:0];

  // Upper write-data bits have no home when NUM_SOURCES < 32.
  assign unused_wrdata = ^bus.WrData;

`ifdef INTC_SW_TRIGGER_EN
  assign sw_set = (wr_en && (bus.RegAddress == 4'h5)) ? wr_src_bits : '0;
`else
  assign sw_set = '0;
`endif

  // ---------------------------------------------------------------------------
  // Pending logic: edges and software triggers set, W1C and Ack clear.
  // Set wins over clear on the same bit in the same cycle.
  // ---------------------------------------------------------------------------
  assign edge_set = IntSrc & ~src_q;
  assign set_vec  = edge_set | sw_set;
  assign clr_vec  = (wr_ipr ? wr_src_bits : '0) | ack_clr;

  always_comb begin
    ack_clr = '0;
    if (state_q == ST_REQ && CpuIntAck) begin
      ack_clr[id_q] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SOURCES; gi++) begin : g_ipr
      assign ipr_d[gi] = set_vec[gi] | (ipr_q[gi] & ~clr_vec[gi]);
    end
  endgenerate

  assign cr_d  = wr_cr  ? bus.WrData[0] : cr_q;
  assign ier_d = wr_ier ? wr_src_bits   : ier_q;

  // ---------------------------------------------------------------------------
  // Eligibility and lowest-index-wins priority
  // ---------------------------------------------------------------------------
  assign eligible = ipr_q & ier_q & {NUM_SOURCES{cr_q}};

  always_comb begin
    win_id = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id = ID_WIDTH'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request / service state machine. The ID is latched on entry to REQ and
  // stays put through SERVICE, so mask writes cannot withdraw a request.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          id_d    = win_id;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (CpuIntAck) begin
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (wr_eoi) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cr_q    <= 1'b0;
      ier_q   <= '0;
      ipr_q   <= '0;
      src_q   <= '0;
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      cr_q    <= cr_d;
      ier_q   <= ier_d;
      ipr_q   <= ipr_d;
      src_q   <= IntSrc;
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  assign CpuIntReq = (state_q == ST_REQ);
  assign CpuIntId  = id_q;

  // ---------------------------------------------------------------------------
  // Combinational read mux; write-only and unmapped addresses read 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    if (bus.BlockSelect) begin
      case (bus.RegAddress)
        4'h0: rd_data[0]                = cr_q;
        4'h1: rd_data[NUM_SOURCES-1:0]  = ier_q;
        4'h2: rd_data[NUM_SOURCES-1:0]  = ipr_q;
        4'h3: begin
          rd_data[31]           = (state_q == ST_SERVICE);
          rd_data[ID_WIDTH-1:0] = id_q;
        end
        default: rd_data = '0;
      endcase
    end
  end

  assign bus.RdData = rd_data;

endmodule

// File: tb/tb_interrupt_controller.sv
`timescale 1ns/1ps
module tb_interrupt_controller;

  localparam int N   = 8;
  localparam int IDW = 3;

  logic           Clock = 1'b0;
  logic           Reset;
  logic [N-1:0]   IntSrc;
  logic           CpuIntAck;
  logic           CpuIntReq;
  logic [IDW-1:0] CpuIntId;

  interrupt_controller_if bus();

  interrupt_controller #(.NUM_SOURCES(N), .ID_WIDTH(IDW)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .IntSrc    (IntSrc),
    .bus       (bus.slave),
    .CpuIntReq (CpuIntReq),
    .CpuIntId  (CpuIntId),
    .CpuIntAck (CpuIntAck)
  );

  always #10 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents plus an abstract handshake phase.
  typedef enum logic [1:0] {M_IDLE, M_REQ, M_SVC} mphase_t;
  logic           m_cr;
  logic [N-1:0]   m_ier;
  logic [N-1:0]   m_ipr;
  logic [N-1:0]   m_prev;
  mphase_t        m_phase;
  logic [IDW-1:0] m_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    logic [31:0] r;
    r = '0;
    case (a)
      0: r[0]     = m_cr;
      1: r[N-1:0] = m_ier;
      2: r[N-1:0] = m_ipr;
      3: begin
        r[31]      = (m_phase == M_SVC);
        r[IDW-1:0] = m_id;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_cr = 1'b0; m_ier = '0; m_ipr = '0; m_prev = '0; m_phase = M_IDLE; m_id = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic         wr;
    logic [N-1:0] set_b, clr_b, elig, data_b;
    int           win;
    wr     = bus.BlockSelect && bus.WrEn;
    data_b = bus.WrData[N-1:0];
    set_b  = IntSrc & ~m_prev;
    clr_b  = '0;
    if (wr && bus.RegAddress == 4'h2) clr_b = clr_b | data_b;
`ifdef INTC_SW_TRIGGER_EN
    if (wr && bus.RegAddress == 4'h5) set_b = set_b | data_b;
`endif
    if (m_phase == M_REQ && CpuIntAck) clr_b[m_id] = 1'b1;
    elig = m_cr ? (m_ipr & m_ier) : '0;
    case (m_phase)
      M_IDLE: begin
        win = lowest_set(elig);
        if (win >= 0) begin
          m_id    = IDW'(win);
          m_phase = M_REQ;
        end
      end
      M_REQ:   if (CpuIntAck) m_phase = M_SVC;
      default: if (wr && bus.RegAddress == 4'h4) m_phase = M_IDLE;
    endcase
    m_ipr = (m_ipr & ~clr_b) | set_b;
    if (wr && bus.RegAddress == 4'h0) m_cr  = bus.WrData[0];
    if (wr && bus.RegAddress == 4'h1) m_ier = data_b;
    m_prev = IntSrc;
  endtask

  // Compare outputs and every register readback against the model.
  task automatic check_all(input string tag);
    chk({tag, ".req"}, {31'b0, CpuIntReq}, {31'b0, m_phase == M_REQ});
    chk({tag, ".id"}, {29'b0, CpuIntId}, {29'b0, m_id});
    bus.WrEn = 1'b0;
    for (int a = 0; a < 6; a++) begin
      bus.BlockSelect = 1'b1;
      bus.RegAddress  = 4'(a);
      #1;
      chk($sformatf("%s.rd%0h", tag, a), bus.RdData, exp_rd(a));
    end
    bus.BlockSelect = 1'b0;
    bus.RegAddress  = 4'h2;
    #1;
    chk({tag, ".nosel"}, bus.RdData, 32'h0);
    bus.RegAddress = 4'h0;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge Clock);
    #1;
    bus.WrEn        = 1'b0;
    bus.BlockSelect = 1'b0;
    CpuIntAck       = 1'b0;
    check_all(tag);
  endtask

  task automatic wr_reg(input string tag, input logic [3:0] a, input logic [31:0] d);
    bus.BlockSelect = 1'b1;
    bus.WrEn        = 1'b1;
    bus.RegAddress  = a;
    bus.WrData      = d;
    tick(tag);
  endtask

  task automatic ack(input string tag);
    CpuIntAck = 1'b1;
    tick(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    Reset           = 1'b0;
    IntSrc          = '0;
    CpuIntAck       = 1'b0;
    bus.BlockSelect = 1'b0;
    bus.WrEn        = 1'b0;
    bus.RegAddress  = 4'h0;
    bus.WrData      = '0;
    model_reset();
    #5;
    check_all("reset");
    @(negedge Clock);
    Reset = 1'b1;

    // Single source handshake
    wr_reg("t2.cr", 4'h0, 32'h1);
    wr_reg("t2.ier", 4'h1, 32'h01);
    IntSrc = 8'h01; tick("t2.edge");
    IntSrc = 8'h00; tick("t2.req");
    ack("t2.ack");
    wr_reg("t2.eoi", 4'h4, 32'h0);
    tick("t2.idle");

    // Two simultaneous sources, lowest index first
    wr_reg("t3.ier", 4'h1, 32'hFF);
    IntSrc = 8'h24; tick("t3.edge");
    IntSrc = 8'h00; tick("t3.req2");
    ack("t3.ack2");
    wr_reg("t3.eoi2", 4'h4, 32'h0);
    tick("t3.req5");
    ack("t3.ack5");
    wr_reg("t3.eoi5", 4'h4, 32'h0);

    // Global disable, W1C, then enable
    wr_reg("t4.cr0", 4'h0, 32'h0);
    IntSrc = 8'h08; tick("t4.edge");
    IntSrc = 8'h00; tick("t4.noreq");
    wr_reg("t4.w1c", 4'h2, 32'h08);
    IntSrc = 8'h08; tick("t4.edge2");
    IntSrc = 8'h00; tick("t4.pend");
    wr_reg("t4.cr1", 4'h0, 32'h1);
    tick("t4.req3");
    ack("t4.ack");
    wr_reg("t4.eoi", 4'h4, 32'h0);

    // Held level sets once; mask write does not withdraw a request
    IntSrc = 8'h02;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) wr_reg("t5.ier0", 4'h1, 32'h0);
      else        tick("t5.hold");
    end
    ack("t5.ack");
    tick("t5.svc");
    IntSrc = 8'h00;
    wr_reg("t5.eoi", 4'h4, 32'h0);
    wr_reg("t5.ier", 4'h1, 32'hFF);

    // Reset during service, then software trigger (or unmapped 4'h5)
    IntSrc = 8'h40; tick("t6.edge");
    IntSrc = 8'h00; tick("t6.req");
    ack("t6.ack");
    do_reset("t6.rst");
    wr_reg("t6.cr", 4'h0, 32'h1);
    wr_reg("t6.ier", 4'h1, 32'hFF);
    wr_reg("t6.swtr", 4'h5, 32'h10);
    tick("t6.req4");
    ack("t6.ack4");
    wr_reg("t6.eoi", 4'h4, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      int r;
      IntSrc = IntSrc ^ N'($urandom & $urandom & $urandom);
      r = $urandom_range(0, 11);
      bus.WrData = $urandom;
      case (r)
        0: begin bus.BlockSelect = 1'b1; bus.WrEn = 1'b1; bus.RegAddress = 4'h0;
                 bus.WrData = {31'b0, $urandom_range(0, 3) != 0}; end
        1: begin bus.BlockSelect = 1'b1; bus.WrEn = 1'b1; bus.RegAddress = 4'h1; end
        2: begin bus.BlockSelect = 1'b1; bus.WrEn = 1'b1; bus.RegAddress = 4'h2; end
        3: begin bus.BlockSelect = 1'b1; bus.WrEn = 1'b1; bus.RegAddress = 4'h4; end
        4: begin bus.BlockSelect = 1'b1; bus.WrEn = 1'b1; bus.RegAddress = 4'h5;
                 bus.WrData = $urandom & $urandom; end
        5: begin bus.BlockSelect = 1'b1; bus.WrEn = 1'b1;
                 bus.RegAddress = 4'($urandom_range(0, 15)); end
        6: begin bus.BlockSelect = 1'b0; bus.WrEn = 1'b1;
                 bus.RegAddress = 4'($urandom_range(0, 5)); end
        default: begin bus.BlockSelect = 1'b0; bus.WrEn = 1'b0; end
      endcase
      CpuIntAck = (m_phase == M_REQ) ? ($urandom_range(0, 2) == 0)
                                     : ($urandom_range(0, 15) == 0);
      tick($sformatf("rnd%0d", c));
      if (c % 137 == 136) do_reset($sformatf("rnd%0d.rst", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
